// File: rtl/cordic_pkg.sv
// Shared constants and payload types for the CORDIC full-circle wrapper.
// Angles are unsigned 9.8 degrees; results are signed 17-bit with 8 fraction bits.
package cordic_pkg;

    localparam int unsigned ANGLE_IN_WIDTH = 17;
    localparam int unsigned CORE_WIDTH     = 16;
    localparam int unsigned OUT_WIDTH      = 17;

    // Quadrant boundaries in 9.8 degrees
    localparam logic [ANGLE_IN_WIDTH-1:0] D90  = 17'h05A00;
    localparam logic [ANGLE_IN_WIDTH-1:0] D180 = 17'h0B400;
    localparam logic [ANGLE_IN_WIDTH-1:0] D270 = 17'h10E00;
    localparam logic [ANGLE_IN_WIDTH-1:0] D360 = 17'h16800;

    typedef logic [1:0] quad_t;

    // Tag that rides alongside the core pipeline
    typedef struct packed {
        logic  valid;
        quad_t q;
        logic  err;
    } tag_t;

    // Sign-restored result stored in the output FIFO
    typedef struct packed {
        logic [OUT_WIDTH-1:0] x;
        logic [OUT_WIDTH-1:0] y;
        logic                 err;
    } result_t;

    localparam int unsigned RESULT_WIDTH = $bits(result_t);

endpackage

// File: rtl/cordic_out_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible whenever rd_valid is high.
// Ports: clk, reset (sync, active-high), wr_en/wr_data (push), rd_en (pop when
// rd_valid), rd_data (head, zero when empty), rd_valid, count (occupancy).
module cordic_out_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign pop  = rd_en && (count != '0);
    // A write into a full FIFO is only taken when the head leaves the same cycle
    assign push = wr_en && ((count < CW'(DEPTH)) || pop);

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage array, no reset needed since the head is masked when empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/cordic_quadrant_wrap.sv
// Full-circle front/back end around a fixed-latency first-quadrant CORDIC core.
// Folds [0,360) degree angles into quadrant 0, tags them through the core
// latency, restores output signs and buffers results behind a credit check.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_degree (angle in);
// core_degree (to core), core_x/core_y (from core); out_valid/out_ready,
// out_x/out_y (signed cos/sin), out_err (input was >= 360).
module cordic_quadrant_wrap
    import cordic_pkg::*;
#(
    parameter int unsigned CORE_LATENCY = 6,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ANGLE_IN_WIDTH-1:0] in_degree,
    output logic [CORE_WIDTH-1:0]     core_degree,
    input  logic [CORE_WIDTH-1:0]     core_x,
    input  logic [CORE_WIDTH-1:0]     core_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_WIDTH-1:0]      out_x,
    output logic [OUT_WIDTH-1:0]      out_y,
    output logic                      out_err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic                  accept;
    quad_t                 fold_q;
    logic [CORE_WIDTH-1:0] fold_r;
    logic                  fold_err;
    tag_t                  fold_tag;
    tag_t                  tag_line [CORE_LATENCY];
    tag_t                  tail;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      fifo_count;
    logic [OUT_WIDTH-1:0]  x_ext;
    logic [OUT_WIDTH-1:0]  y_ext;
    result_t               wr_res;
    result_t               head;

    // Credits: every accepted angle reserves a FIFO slot until it is popped
    assign in_ready = (SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
    assign accept   = in_valid && in_ready;

    // Quadrant fold decode
    always_comb begin
        fold_q   = 2'd0;
        fold_r   = '0;
        fold_err = 1'b0;
        if (in_degree < D90) begin
            fold_r = CORE_WIDTH'(in_degree);
        end else if (in_degree < D180) begin
            fold_q = 2'd1;
            fold_r = CORE_WIDTH'(in_degree - D90);
        end else if (in_degree < D270) begin
            fold_q = 2'd2;
            fold_r = CORE_WIDTH'(in_degree - D180);
        end else if (in_degree < D360) begin
            fold_q = 2'd3;
            fold_r = CORE_WIDTH'(in_degree - D270);
        end else begin
            fold_err = 1'b1;
        end
    end

    // Fold register; core_degree holds its last value while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            core_degree <= '0;
            fold_tag    <= '0;
        end else begin
            fold_tag.valid <= accept;
            if (accept) begin
                core_degree  <= fold_r;
                fold_tag.q   <= fold_q;
                fold_tag.err <= fold_err;
            end
        end
    end

    // Tag line matching the core latency; never stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(CORE_LATENCY); i++) begin
                tag_line[i] <= '0;
            end
        end else begin
            tag_line[0] <= fold_tag;
            for (int i = 1; i < int'(CORE_LATENCY); i++) begin
                tag_line[i] <= tag_line[i-1];
            end
        end
    end

    assign tail = tag_line[CORE_LATENCY-1];

    // Sign restore on the tag tail
    assign x_ext = {1'b0, core_x};
    assign y_ext = {1'b0, core_y};

    always_comb begin
        wr_res     = '0;
        wr_res.err = tail.err;
        unique case (tail.q)
            2'd0: begin wr_res.x = x_ext;  wr_res.y = y_ext;  end
            2'd1: begin wr_res.x = -y_ext; wr_res.y = x_ext;  end
            2'd2: begin wr_res.x = -x_ext; wr_res.y = -y_ext; end
            default: begin wr_res.x = y_ext; wr_res.y = -x_ext; end
        endcase
    end

    // In-flight counter; accept and tail write in one cycle cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + CNT_W'(accept) - CNT_W'(tail.valid);
        end
    end

    cordic_out_fifo #(
        .WIDTH (RESULT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (tail.valid),
        .wr_data  (wr_res),
        .rd_en    (out_ready),
        .rd_data  (head),
        .rd_valid (out_valid),
        .count    (fifo_count)
    );

    assign out_x   = head.x;
    assign out_y   = head.y;
    assign out_err = head.err;

endmodule

// File: tb/tb_cordic_quadrant_wrap.sv
// Scoreboard bench for cordic_quadrant_wrap with a behavioural 6-stage core model.
module tb_cordic_quadrant_wrap;

    localparam int CORE_LATENCY = 6;
    localparam int FIFO_DEPTH   = 16;
    localparam int NV           = 11;

    localparam logic [16:0] ANG [NV] = '{17'h01E00, 17'h07800, 17'h0D200, 17'h12C00,
                                         17'h05A00, 17'h167FF, 17'h19000, 17'h00000,
                                         17'h16800, 17'h02D00, 17'h0B400};
    localparam logic [15:0] CD  [NV] = '{16'h1E00, 16'h1E00, 16'h1E00, 16'h1E00,
                                         16'h0000, 16'h59FF, 16'h0000, 16'h0000,
                                         16'h0000, 16'h2D00, 16'h0000};
    localparam int          EX  [NV] = '{222, -128, -222, 128, 0, 256, 256, 256, 256, 181, -256};
    localparam int          EY  [NV] = '{128, 222, -128, -222, 256, 0, 0, 0, 0, 181, 0};
    localparam bit          EE  [NV] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};

    typedef struct {
        logic [16:0] x;
        logic [16:0] y;
        logic        err;
        int          due;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_degree;
    logic [15:0] core_degree;
    logic [15:0] core_x;
    logic [15:0] core_y;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_x;
    logic [16:0] out_y;
    logic        out_err;

    exp_t        exp_q [$];
    logic [15:0] cd_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          bp_watch = 0;
    int          phase_acc = 0;
    int          first_stall = -1;
    bit          post_rst_watch = 0;
    int          post_rst_cnt = 0;

    logic [15:0] mx [CORE_LATENCY];
    logic [15:0] my [CORE_LATENCY];
    real         ang_rad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_quadrant_wrap #(
        .CORE_LATENCY (CORE_LATENCY),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_degree   (in_degree),
        .core_degree (core_degree),
        .core_x      (core_x),
        .core_y      (core_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_err     (out_err)
    );

    // Reference core: exact cos/sin x256, CORE_LATENCY register stages
    always @(posedge clk) begin
        ang_rad = real'(core_degree) / 256.0 * 3.14159265358979 / 180.0;
        mx[0] <= 16'($rtoi($cos(ang_rad) * 256.0 + 0.5));
        my[0] <= 16'($rtoi($sin(ang_rad) * 256.0 + 0.5));
        for (int i = 1; i < CORE_LATENCY; i++) begin
            mx[i] <= mx[i-1];
            my[i] <= my[i-1];
        end
    end
    assign core_x = mx[CORE_LATENCY-1];
    assign core_y = my[CORE_LATENCY-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Present one angle and push its expectation once the handshake is certain
    task automatic send(input int idx, input bit lat);
        bit   done = 0;
        exp_t e;
        in_valid  = 1'b1;
        in_degree = ANG[idx];
        for (int w = 0; w < 200 && !done; w++) begin
            #1;
            if (in_ready) begin
                e.x = 17'(EX[idx]);
                e.y = 17'(EY[idx]);
                e.err = EE[idx];
                e.due = cyc + 8;
                e.lat = lat;
                exp_q.push_back(e);
                cd_q.push_back(CD[idx]);
                phase_acc++;
                done = 1;
            end else if (bp_watch && first_stall < 0) begin
                first_stall = phase_acc;
            end
            @(negedge clk);
        end
        if (!done) check("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: core_degree one cycle after accept, results on each pop
    initial begin : monitor
        bit   cd_pend = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                cd_pend = 0;
            end else begin
                if (cd_pend) begin
                    if (cd_q.size() == 0) check("cd_unexpected", 32'd1, 32'd0);
                    else check("core_degree", 32'(core_degree), 32'(cd_q.pop_front()));
                end
                cd_pend = in_valid && in_ready;
                if (out_valid && post_rst_watch) post_rst_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("out_unexpected", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_x", 32'(out_x), 32'(e.x));
                        check("out_y", 32'(out_y), 32'(e.y));
                        check("out_err", 32'(out_err), 32'(e.err));
                        if (e.lat) check("latency", 32'(cyc), 32'(e.due));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_degree = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_core_degree", 32'(core_degree), 32'd0);
        @(negedge clk);

        // Isolated vectors with latency check
        for (int i = 0; i < NV; i++) begin
            send(i, 1'b1);
            in_valid = 1'b0;
            repeat (12) @(negedge clk);
        end
        drain();

        // Back-to-back stream, consumer always ready
        for (int i = 0; i < 22; i++) send(i % NV, 1'b0);
        in_valid = 1'b0;
        drain();

        // Stream of 40 with consumer stalled for 20 cycles
        bp_watch    = 1;
        phase_acc   = 0;
        first_stall = -1;
        fork
            begin
                out_ready = 1'b0;
                repeat (20) @(negedge clk);
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) send((i * 3) % NV, 1'b0);
                in_valid = 1'b0;
            end
        join
        bp_watch = 0;
        drain();
        check("credit_stall_at", 32'(first_stall), 32'd16);
        check("stream_accepts", 32'(phase_acc), 32'd40);

        // Reset three cycles after four accepts flushes everything
        for (int i = 0; i < 4; i++) send(i, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        cd_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        post_rst_watch = 1;
        repeat (20) @(negedge clk);
        post_rst_watch = 0;
        check("post_rst_out_valid_cnt", 32'(post_rst_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
